// File: rtl/decode_stage_if.sv
// Bundle between fetch/EX/WB and the decode stage: fetch inputs, hazard info,
// write-back port, stall back to fetch and the registered ID/EX outputs.
interface decode_stage_if;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc4;
  logic        flush;
  logic        ex_mem_read;
  logic [4:0]  ex_rt;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        stall;
  logic        id_valid;
  logic [31:0] id_pc4;
  logic [5:0]  id_opcode;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic [4:0]  id_shamt;
  logic [5:0]  id_funct;
  logic [31:0] id_imm_sext;
  logic [31:0] id_jump_target;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;

  modport master (
    output if_valid, if_instr, if_pc4, flush, ex_mem_read, ex_rt,
           wb_we, wb_addr, wb_data,
    input  stall, id_valid, id_pc4, id_opcode, id_rs, id_rt, id_rd, id_shamt,
           id_funct, id_imm_sext, id_jump_target, id_rs_data, id_rt_data
  );

  modport slave (
    input  if_valid, if_instr, if_pc4, flush, ex_mem_read, ex_rt,
           wb_we, wb_addr, wb_data,
    output stall, id_valid, id_pc4, id_opcode, id_rs, id_rt, id_rd, id_shamt,
           id_funct, id_imm_sext, id_jump_target, id_rs_data, id_rt_data
  );
endinterface

// File: rtl/decode_stage.sv
// MIPS instruction-decode stage: IF/ID register, bypassed register file,
// field decode, load-use stall detection and the ID/EX output register.
module decode_stage #(
  parameter int RF_DEPTH = 32
) (
  input logic           clk,
  input logic           reset,
  decode_stage_if.slave bus
);

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic uses_rt(input logic [5:0] op);
    return (op == 6'h00) || (op == 6'h04) || (op == 6'h05) || (op == 6'h2B);
  endfunction

  logic        vld_p0;
  logic [31:0] instr_p0;
  logic [31:0] pc4_p0;
  logic [31:0] rf [RF_DEPTH];
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        stall;

  logic        vld_p1;
  logic [31:0] pc4_p1;
  logic [31:0] instr_p1;
  logic [31:0] imm_p1;
  logic [31:0] jt_p1;
  logic [31:0] rs_data_p1;
  logic [31:0] rt_data_p1;

  // Stage p0: IF/ID register
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0   <= 1'b0;
      instr_p0 <= '0;
      pc4_p0   <= '0;
    end else if (bus.flush) begin
      vld_p0 <= 1'b0;
    end else if (!stall) begin
      vld_p0   <= bus.if_valid;
      instr_p0 <= bus.if_instr;
      pc4_p0   <= bus.if_pc4;
    end
  end

  assign rs = instr_p0[25:21];
  assign rt = instr_p0[20:16];

  // Register 0 is never written, so it reads back its reset value of zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RF_DEPTH; i++) rf[i] <= '0;
    end else if (bus.wb_we && bus.wb_addr != 5'd0) begin
      rf[bus.wb_addr] <= bus.wb_data;
    end
  end

  always_comb begin
    rs_data = rf[rs];
    rt_data = rf[rt];
    if (bus.wb_we && bus.wb_addr != 5'd0 && bus.wb_addr == rs) rs_data = bus.wb_data;
    if (bus.wb_we && bus.wb_addr != 5'd0 && bus.wb_addr == rt) rt_data = bus.wb_data;
  end

  assign stall = vld_p0 && bus.ex_mem_read && (bus.ex_rt != 5'd0) &&
                 ((bus.ex_rt == rs) || (uses_rt(instr_p0[31:26]) && bus.ex_rt == rt));

  // Stage p1: ID/EX register; flush, stall and invalid IF/ID all yield a zero bubble
  always_ff @(posedge clk) begin
    if (reset || bus.flush || stall || !vld_p0) begin
      vld_p1     <= 1'b0;
      pc4_p1     <= '0;
      instr_p1   <= '0;
      imm_p1     <= '0;
      jt_p1      <= '0;
      rs_data_p1 <= '0;
      rt_data_p1 <= '0;
    end else begin
      vld_p1     <= 1'b1;
      pc4_p1     <= pc4_p0;
      instr_p1   <= instr_p0;
      imm_p1     <= sext16(instr_p0[15:0]);
      jt_p1      <= {pc4_p0[31:28], instr_p0[25:0], 2'b00};
      rs_data_p1 <= rs_data;
      rt_data_p1 <= rt_data;
    end
  end

  assign bus.stall          = stall;
  assign bus.id_valid       = vld_p1;
  assign bus.id_pc4         = pc4_p1;
  assign bus.id_opcode      = instr_p1[31:26];
  assign bus.id_rs          = instr_p1[25:21];
  assign bus.id_rt          = instr_p1[20:16];
  assign bus.id_rd          = instr_p1[15:11];
  assign bus.id_shamt       = instr_p1[10:6];
  assign bus.id_funct       = instr_p1[5:0];
  assign bus.id_imm_sext    = imm_p1;
  assign bus.id_jump_target = jt_p1;
  assign bus.id_rs_data     = rs_data_p1;
  assign bus.id_rt_data     = rt_data_p1;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: hand-computed vectors for decode, bypass,
// register-0 protection, load-use stall, flush priority, jump and reset.
module tb_decode_stage;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  decode_stage_if bus ();

  decode_stage #(.RF_DEPTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic present(input logic [31:0] instr, input logic [31:0] pc4);
    bus.if_valid = 1'b1;
    bus.if_instr = instr;
    bus.if_pc4   = pc4;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset           = 1'b1;
    bus.if_valid    = 1'b0;
    bus.if_instr    = '0;
    bus.if_pc4      = '0;
    bus.flush       = 1'b0;
    bus.ex_mem_read = 1'b0;
    bus.ex_rt       = '0;
    bus.wb_we       = 1'b0;
    bus.wb_addr     = '0;
    bus.wb_data     = '0;
    @(negedge clk);
    step();
    step();
    check_eq("rst_stall", {31'd0, bus.stall}, 32'd0);
    check_eq("rst_valid", {31'd0, bus.id_valid}, 32'd0);
    check_eq("rst_pc4", bus.id_pc4, 32'd0);
    check_eq("rst_rsdata", bus.id_rs_data, 32'd0);

    // addi $8,$0,-4
    reset = 1'b0;
    present(32'h2008_FFFC, 32'h0000_0004);
    step();
    bus.if_valid = 1'b0;
    step();
    check_eq("addi_valid", {31'd0, bus.id_valid}, 32'd1);
    check_eq("addi_opcode", {26'd0, bus.id_opcode}, 32'h08);
    check_eq("addi_rt", {27'd0, bus.id_rt}, 32'd8);
    check_eq("addi_imm", bus.id_imm_sext, 32'hFFFF_FFFC);
    check_eq("addi_pc4", bus.id_pc4, 32'h4);
    check_eq("addi_rsdata", bus.id_rs_data, 32'd0);

    // add $10,$9,$9 with same-cycle write-back of $9
    present(32'h0129_5020, 32'h0000_0008);
    step();
    bus.if_valid = 1'b0;
    bus.wb_we    = 1'b1;
    bus.wb_addr  = 5'd9;
    bus.wb_data  = 32'h1234_5678;
    step();
    check_eq("byp_rsdata", bus.id_rs_data, 32'h1234_5678);
    check_eq("byp_rtdata", bus.id_rt_data, 32'h1234_5678);
    check_eq("byp_rd", {27'd0, bus.id_rd}, 32'd10);
    check_eq("byp_funct", {26'd0, bus.id_funct}, 32'h20);

    // writes to $0 are discarded, including on the bypass path
    bus.wb_addr = 5'd0;
    bus.wb_data = 32'hDEAD_BEEF;
    present(32'h2008_FFFC, 32'h0000_000C);
    step();
    bus.if_valid = 1'b0;
    step();
    check_eq("r0_rsdata", bus.id_rs_data, 32'd0);
    bus.wb_we = 1'b0;

    // I-type: load into rt must not stall since rt is not a source
    present(32'h2008_FFFC, 32'h0000_000C);
    step();
    bus.if_valid    = 1'b0;
    bus.ex_mem_read = 1'b1;
    bus.ex_rt       = 5'd8;
    #1;
    check_eq("itype_nostall", {31'd0, bus.stall}, 32'd0);
    bus.ex_mem_read = 1'b0;

    // add $10,$8,$9 behind a load of $9 (rt) then $8 (rs)
    present(32'h0109_5020, 32'h0000_0010);
    step();
    bus.ex_mem_read = 1'b1;
    bus.ex_rt       = 5'd9;
    bus.if_valid    = 1'b0;
    #1;
    check_eq("lu_rt_stall", {31'd0, bus.stall}, 32'd1);
    bus.ex_rt = 5'd8;
    present(32'h2008_FFFC, 32'h0000_0020);
    #1;
    check_eq("lu_rs_stall", {31'd0, bus.stall}, 32'd1);
    step();
    check_eq("lu_bubble_valid", {31'd0, bus.id_valid}, 32'd0);
    check_eq("lu_bubble_pc4", bus.id_pc4, 32'd0);
    bus.ex_mem_read = 1'b0;
    #1;
    check_eq("lu_stall_drop", {31'd0, bus.stall}, 32'd0);
    step();
    bus.if_valid = 1'b0;
    check_eq("lu_add_valid", {31'd0, bus.id_valid}, 32'd1);
    check_eq("lu_add_pc4", bus.id_pc4, 32'h10);
    check_eq("lu_add_rs", {27'd0, bus.id_rs}, 32'd8);
    check_eq("lu_add_rtdata", bus.id_rt_data, 32'h1234_5678);
    step();
    check_eq("lu_next_valid", {31'd0, bus.id_valid}, 32'd1);
    check_eq("lu_next_pc4", bus.id_pc4, 32'h20);

    // flush while the stall condition holds
    present(32'h0109_5020, 32'h0000_0030);
    step();
    bus.if_valid    = 1'b0;
    bus.ex_mem_read = 1'b1;
    bus.ex_rt       = 5'd8;
    bus.flush       = 1'b1;
    #1;
    check_eq("fl_pre_stall", {31'd0, bus.stall}, 32'd1);
    step();
    check_eq("fl_valid", {31'd0, bus.id_valid}, 32'd0);
    check_eq("fl_rs", {27'd0, bus.id_rs}, 32'd0);
    check_eq("fl_pc4", bus.id_pc4, 32'd0);
    check_eq("fl_stall_after", {31'd0, bus.stall}, 32'd0);
    bus.flush       = 1'b0;
    bus.ex_mem_read = 1'b0;
    step();
    check_eq("fl_ifid_empty", {31'd0, bus.id_valid}, 32'd0);

    // j with upper PC bits taken from its own PC+4
    present(32'h0810_0003, 32'h4000_0010);
    step();
    bus.if_valid = 1'b0;
    step();
    check_eq("j_valid", {31'd0, bus.id_valid}, 32'd1);
    check_eq("j_opcode", {26'd0, bus.id_opcode}, 32'h02);
    check_eq("j_target", bus.id_jump_target, 32'h4040_000C);

    // reset mid-stream discards the instruction and register contents
    present(32'h0129_5020, 32'h0000_0050);
    step();
    reset        = 1'b1;
    bus.if_valid = 1'b0;
    step();
    check_eq("mrst_valid", {31'd0, bus.id_valid}, 32'd0);
    reset = 1'b0;
    present(32'h0129_5020, 32'h0000_0054);
    step();
    bus.if_valid = 1'b0;
    step();
    check_eq("mrst_valid2", {31'd0, bus.id_valid}, 32'd1);
    check_eq("mrst_rsdata", bus.id_rs_data, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction-decode stage of the pipelined MIPS core, directly downstream of the fetch stage.
- Contains, in order:
  - the IF/ID pipeline register, which captures the fetched instruction and PC+4;
  - the 32x32 register file, with write-back bypass;
  - the field decoder and sign extender;
  - the registered ID/EX output bundle.
- Detects load-use hazards and drives `stall` back to fetch.

Parameters:
- RF_DEPTH, 32, number of architectural registers. Fixed at 32; register 0 is hardwired to zero.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- if_valid  in  1  fetch presents a valid instruction this cycle.
- if_instr  in  32  fetched instruction word.
- if_pc4  in  32  PC+4 of that instruction.
- flush  in  1  squash the IF/ID and ID/EX contents (taken branch or jump resolved in EX).
- ex_mem_read  in  1  the instruction currently in EX is a load.
- ex_rt  in  5  destination register of that load.
- wb_we  in  1  write-back enable.
- wb_addr  in  5  write-back register index.
- wb_data  in  32  write-back data.
- stall  out  1  hold PC and IF/ID this cycle (combinational).
- id_valid  out  1  ID/EX bundle holds a real instruction.
- id_pc4  out  32  PC+4 of that instruction.
- id_opcode  out  6  instr[31:26].
- id_rs  out  5  instr[25:21].
- id_rt  out  5  instr[20:16].
- id_rd  out  5  instr[15:11].
- id_shamt  out  5  instr[10:6].
- id_funct  out  6  instr[5:0].
- id_imm_sext  out  32  instr[15:0] sign-extended to 32 bits.
- id_jump_target  out  32  {pc4[31:28], instr[25:0], 2'b00}.
- id_rs_data  out  32  value read from register rs.
- id_rt_data  out  32  value read from register rt.

Behaviour:
- Reset (synchronous):
  - IF/ID valid, instruction and PC+4 are cleared to 0.
  - All id_* outputs are cleared to 0.
  - All 32 registers are cleared to 0.
  - stall therefore reads 0 immediately after reset.
- Latency: an instruction accepted at edge N (if_valid=1, stall=0, flush=0) appears on id_* after edge N+1. In-order; no instruction is dropped unless flushed.
- IF/ID update priority at each edge: reset > flush (valid<=0) > stall (hold) > load if_valid/if_instr/if_pc4.
- ID/EX update priority at each edge: reset > flush (bubble) > stall (bubble) > load the decoded IF/ID contents with id_valid = IF/ID valid.
- Bubble definition: id_valid=0 and every id_* field = 0.
- Invalid IF/ID contents: when IF/ID valid=0, the ID/EX update also produces all-zero fields.
- uses_rt is 1 for:
  - opcode 0x00 (R-type);
  - 0x04 (beq);
  - 0x05 (bne);
  - 0x2B (sw).
- stall = IF/ID valid & ex_mem_read & (ex_rt != 0) & ((ex_rt == rs) | (uses_rt & ex_rt == rt)).
- stall is purely combinational from the current state and inputs. It is asserted for exactly one cycle per load-use pair, because the bubble clears EX on the following cycle.
- flush and stall together: flush wins. IF/ID is cleared and stall has no effect on that edge.
- Register file write: at the rising edge when wb_we=1 and wb_addr!=0. Writes to register 0 are discarded; register 0 always reads 0.
- Register file read: combinational from the IF/ID rs/rt fields.
- Write-back bypass applies when wb_we=1, wb_addr!=0 and wb_addr equals the read index. The read then returns wb_data, so a write and a read of the same register in the same cycle yields the new value.
- Sign extension: id_imm_sext[31:16] = instr[15].
- Jump target uses the PC+4 of the same instruction.
- Reset asserted mid-stream: all in-flight instructions are discarded and register contents are lost. The first instruction accepted after reset deasserts appears on id_* two edges later.

Test Plan:
- Reset then a single instruction:
  - stimulus: hold reset 2 cycles, then present if_instr=0x2008_FFFC (addi $8,$0,-4) with if_pc4=0x0000_0004, if_valid=1;
  - required response: one edge later id_valid=1, id_rt=8, id_imm_sext=0xFFFF_FFFC, id_pc4=0x4, id_rs_data=0.
- Write-back bypass:
  - stimulus: wb_we=1, wb_addr=9, wb_data=0x1234_5678 in the same cycle IF/ID holds add $10,$9,$9 (0x0129_5020);
  - required response: id_rs_data = id_rt_data = 0x1234_5678.
- Register 0 protection:
  - stimulus: wb_we=1, wb_addr=0, wb_data=0xDEAD_BEEF, then decode an instruction with rs=0;
  - required response: id_rs_data=0.
- Load-use stall:
  - stimulus: ex_mem_read=1, ex_rt=8, IF/ID holds add $10,$8,$9;
  - required response: stall=1 for one cycle, id_valid=0 that edge, IF/ID unchanged. With ex_mem_read=0 on the next cycle, the add appears on id_* with id_valid=1.
- Flush over stall:
  - stimulus: flush=1 while the stall condition is true;
  - required response: next edge IF/ID valid=0, id_valid=0, all id_* fields 0, and stall=0 on the following cycle.
- Jump decode:
  - stimulus: if_instr=0x0810_0003 (j) with if_pc4=0x4000_0010;
  - required response: id_jump_target=0x4040_000C.
